// File: rtl/param_seq_alu_if.sv
// Handshake bus for param_seq_alu: operand/op request channel and registered result channel.
interface param_seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             err;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, zero, cout, overflow, err
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, zero, cout, overflow, err
  );
endinterface

// File: rtl/param_seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshake; AND/OR/ADD/SUB/SLT in one cycle.
// Define PARAM_SEQ_ALU_MUL_EN to add the WIDTH-cycle shift-add multiply on op 101.
module param_seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  param_seq_alu_if.slave    bus
);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  if (WIDTH < 2 || (2 ** CNT_W) <= WIDTH) begin : g_param_check
    $error("param_seq_alu: need WIDTH >= 2 and 2**CNT_W > WIDTH");
  end

`ifdef PARAM_SEQ_ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             err_reg, err_next;

  logic [WIDTH-1:0] and_bits, or_bits;
  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout, alu_ovf, alu_err;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
    assign and_bits[gi] = bus.a[gi] & bus.b[gi];
    assign or_bits[gi]  = bus.a[gi] | bus.b[gi];
  end

  // Subtraction as a + ~b + 1 so cout reads as "no borrow".
  assign add_sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf = (bus.a[MSB] == bus.b[MSB]) && (add_sum[MSB] != bus.a[MSB]);
  assign sub_ovf = (bus.a[MSB] != bus.b[MSB]) && (sub_sum[MSB] != bus.a[MSB]);

  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    alu_ovf    = 1'b0;
    alu_err    = 1'b0;
    case (bus.op)
      OP_AND: alu_result = and_bits;
      OP_OR:  alu_result = or_bits;
      OP_ADD: begin
        alu_result = add_sum[MSB:0];
        alu_cout   = add_sum[WIDTH];
        alu_ovf    = add_ovf;
      end
      OP_SUB: begin
        alu_result = sub_sum[MSB:0];
        alu_cout   = sub_sum[WIDTH];
        alu_ovf    = sub_ovf;
      end
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, sub_sum[MSB] ^ sub_ovf};
      default: alu_err = 1'b1;
    endcase
  end

`ifdef PARAM_SEQ_ALU_MUL_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mcand_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH:0]     mul_upper;

  // Multiplier bits drain from acc[0] while partial product fills the top half.
  assign mul_upper = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                     (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  assign acc_step  = {mul_upper, acc_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == S_IDLE && bus.in_valid && bus.op == OP_MUL) begin
      acc_reg   <= {{WIDTH{1'b0}}, bus.a};
      mcand_reg <= bus.b;
      cnt_reg   <= '0;
    end else if (state_reg == S_MUL) begin
      acc_reg   <= acc_step;
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end
`endif

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    cout_next   = cout_reg;
    ovf_next    = ovf_reg;
    err_next    = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.in_valid) begin
`ifdef PARAM_SEQ_ALU_MUL_EN
          if (bus.op == OP_MUL) state_next = S_MUL;
          else
`endif
          begin
            state_next  = S_DONE;
            result_next = alu_result;
            zero_next   = (alu_result == '0);
            cout_next   = alu_cout;
            ovf_next    = alu_ovf;
            err_next    = alu_err;
          end
        end
      end
`ifdef PARAM_SEQ_ALU_MUL_EN
      S_MUL: begin
        if (cnt_reg == CNT_LAST) begin
          state_next  = S_DONE;
          result_next = acc_step[WIDTH-1:0];
          zero_next   = (acc_step[WIDTH-1:0] == '0);
          cout_next   = 1'b0;
          ovf_next    = |acc_step[2*WIDTH-1:WIDTH];
          err_next    = 1'b0;
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      cout_reg   <= cout_next;
      ovf_reg    <= ovf_next;
      err_reg    <= err_next;
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.err       = err_reg;
endmodule
